// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: access sizes, FSM states and lane masks.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StWait,
    StMerge,
    StResp
  } state_e;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;
  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;

endpackage

// File: rtl/mem_lane_merge.sv
// Little-endian lane handling: merges sub-word write data into an old word and
// extracts a zero-extended, right-justified read value from it.
module mem_lane_merge
  import mem_pkg::*;
(
  input  logic  [31:0] old_i,
  input  logic  [31:0] wdata_i,
  input  size_e        size_i,
  input  logic  [1:0]  lane_i,
  output logic  [31:0] merged_o,
  output logic  [31:0] rdata_o
);

  logic [31:0] mask;
  logic [4:0]  shamt;

  always_comb begin
    mask  = WORD_MASK;
    shamt = 5'd0;
    unique case (size_i)
      SZ_WORD: begin
        mask  = WORD_MASK;
        shamt = 5'd0;
      end
      SZ_HALF: begin
        mask  = HALF_MASK;
        shamt = {lane_i[1], 4'b0000};
      end
      SZ_BYTE: begin
        mask  = BYTE_MASK;
        shamt = {lane_i, 3'b000};
      end
      // Illegal size leaves the word untouched and reads as zero.
      default: mask = '0;
    endcase
    merged_o = (old_i & ~(mask << shamt)) | ((wdata_i & mask) << shamt);
    rdata_o  = (old_i >> shamt) & mask;
  end

endmodule

// File: rtl/mem_responder.sv
// Req/ack memory responder with configurable latency and read-merge-write sub-word stores.
// Define MEM_RESPONDER_CLEAR_EN to zero the whole array after every reset.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef MEM_RESPONDER_CLEAR_EN
  localparam state_e ResetState = StClear;
`else
  localparam state_e ResetState = StIdle;
`endif

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  size_e             size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       mem_rd;
  logic              mem_we;
  logic [IdxW-1:0]   mem_waddr;
  logic [31:0]       mem_wdata;

  logic              acc_err;
  logic [31:0]       merge_old;
  logic [31:0]       merged;
  logic [31:0]       lane_rdata;

`ifdef MEM_RESPONDER_CLEAR_EN
  logic [IdxW-1:0]   clr_q, clr_d;
`endif

  assign mem_rd    = mem_q[idx_q];
  assign merge_old = (state_q == StMerge) ? word_q : mem_rd;

  mem_lane_merge u_lane_merge (
    .old_i    (merge_old),
    .wdata_i  (wdata_q),
    .size_i   (size_q),
    .lane_i   (lane_q),
    .merged_o (merged),
    .rdata_o  (lane_rdata)
  );

  assign acc_err = (size_i == SZ_ILL)
                 | ((size_i == SZ_HALF) && addr_i[0])
                 | ((size_i == SZ_WORD) && (addr_i[1:0] != 2'b00))
                 | ({2'b00, addr_i[31:2]} >= DEPTH);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    size_d    = size_q;
    lane_d    = lane_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    word_d    = word_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = merged;
`ifdef MEM_RESPONDER_CLEAR_EN
    clr_d     = clr_q;
`endif
    unique case (state_q)
      StClear: begin
`ifdef MEM_RESPONDER_CLEAR_EN
        mem_we    = 1'b1;
        mem_waddr = clr_q;
        mem_wdata = '0;
        if (clr_q == IdxW'(DEPTH - 1)) begin
          state_d = StIdle;
        end else begin
          clr_d = clr_q + 1'b1;
        end
`else
        state_d = StIdle;
`endif
      end
      StIdle: begin
        if (req_i) begin
          we_d    = we_i;
          size_d  = size_e'(size_i);
          lane_d  = addr_i[1:0];
          idx_d   = addr_i[IdxW+1:2];
          wdata_d = wdata_i;
          cnt_d   = 4'(LATENCY - 1);
          if (acc_err) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = StResp;
          end else begin
            err_d   = 1'b0;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            rdata_d = lane_rdata;
            state_d = StResp;
          end else if (size_q == SZ_WORD) begin
            mem_we    = 1'b1;
            mem_wdata = wdata_q;
            state_d   = StResp;
          end else begin
            word_d  = mem_rd;
            state_d = StMerge;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StMerge: begin
        mem_we  = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ResetState;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_WORD;
      lane_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef MEM_RESPONDER_CLEAR_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      clr_q <= '0;
    end else begin
      clr_q <= clr_d;
    end
  end
`endif

  // Reset drops any write that has not yet been committed.
  always_ff @(posedge clk_i) begin
    if (mem_we && !reset_i) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign ack_o   = (state_q == StResp);
  assign err_o   = ack_o & err_q;
  assign rdata_o = rdata_q;
  assign busy_o  = (state_q != StIdle);

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-organised memory responder answering the CPU's memory port with a req/ack handshake and configurable access latency. Supports word, halfword and byte reads and writes; sub-word writes are done internally as read-merge-write, so the CPU datapath needs no byte-combine logic. Sits behind the CPU's address mux and write-data path as a cycle-accurate, verifiable replacement for the fixed-latency memory.

## Interface
Parameters:
- DEPTH, 64: number of 32-bit words; valid word index is 0..DEPTH-1.
- LATENCY, 1: storage access cycles; legal range 1..15.

Ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  request valid; sampled only in IDLE.
- we  in  1  1 = write, 0 = read.
- size  in  2  00 word, 01 halfword, 10 byte; 11 is illegal.
- addr  in  32  byte address.
- wdata  in  32  write data, sub-word taken right-justified from the low bits.
- rdata  out  32  read data, sub-word zero-extended and right-justified; valid only while ack=1.
- ack  out  1  one-cycle completion pulse.
- err  out  1  error flag, qualified by ack.
- busy  out  1  high in every state except IDLE.

## Operation
- Little-endian byte lanes: byte at addr[1:0]=k occupies bits 8k+7:8k.
- States: CLEAR (only with macro), IDLE, WAIT, MERGE, RESP.
- IDLE: when req=1, capture we/size/addr/wdata. The requester may drop req on the next cycle.
- Error check at accept. Any of the following sends the FSM straight to RESP with err=1 and rdata=0, and no storage write:
  - size=11
  - halfword with addr[0]=1
  - word with addr[1:0]≠0
  - addr[31:2] ≥ DEPTH
- WAIT: load counter with LATENCY-1; decrement each cycle. At 0:
  - Read: latch the word, select the lane, go to RESP.
  - Word write: commit wdata, go to RESP.
  - Sub-word write: latch the old word, go to MERGE.
- MERGE: write the old word with the selected lane(s) replaced, go to RESP.
- RESP: ack=1 for exactly one cycle, rdata/err valid. Then go to IDLE. req is ignored during RESP.
- Reset output values: ack=0, err=0, rdata=0, busy=0 (busy=1 with macro). Reset while in WAIT/MERGE aborts the access; an uncommitted write is dropped. Storage is not altered by reset unless the macro is set.

## Timing
- Accept edge = E0.
- Error responses: ack in the cycle after E0.
- Read or word write: ack in the cycle after edge E0+LATENCY.
- Sub-word write: ack one cycle later (after E0+LATENCY+1).
- Write commit occurs on the edge that enters RESP. A read issued in the cycle after ack observes it.
- Maximum throughput: one access per LATENCY+2 cycles (accept in IDLE after RESP).
- rdata holds its value after ack until the next RESP. Consumers sample only when ack=1.

## Configuration
- MEM_RESPONDER_CLEAR_EN defined:
  - After reset, the FSM enters CLEAR and writes zero to word 0..DEPTH-1, one word per cycle.
  - busy=1 and req is ignored throughout, then the FSM goes to IDLE.
  - Reset asserted during CLEAR restarts the sweep from word 0.
- Undefined: reset goes directly to IDLE; storage contents are untouched (X at power-up).

## Structure
- Shared package mem_pkg holds:
  - size encodings (SZ_WORD, SZ_HALF, SZ_BYTE)
  - FSM state encodings
  - lane-select helper constants
- One sub-module, mem_lane_merge (combinational), which:
  - takes old word, wdata, size, addr[1:0];
  - returns the merged write word and the extracted, zero-extended read value.
- FSM, counter and storage array live in mem_responder.

## Test plan
- LATENCY=1: word write 0xDEADBEEF to addr 0x10, then word read 0x10 -> ack on the expected cycle, rdata=0xDEADBEEF, err=0.
- Byte write 0xAA to addr 0x11 over word 0x11223344 -> read 0x10 gives 0x1122AA44. Byte read 0x11 gives 0x000000AA. Write ack comes one cycle later than a word write.
- Halfword read at 0x13 -> ack one cycle after accept, err=1, rdata=0. Word at 0x10 unchanged. Same result for addr=4*DEPTH and for size=11.
- LATENCY=3: read accepted at edge E0 -> ack exactly after edge E0+3. busy=1 from E0 through the ack cycle. req held high during busy -> no second accept.
- Reset asserted during MERGE of a halfword write to 0x20 -> ack never pulses, word 0x20 keeps its old value, outputs at reset values.
- With MEM_RESPONDER_CLEAR_EN, DEPTH=64: reset -> busy=1 for 64 cycles, req ignored. Then a read of any word returns 0.
